// File: rtl/control_sequencer_if.sv
// Fetch-to-control bundle between instruction memory, the control sequencer and CPU_TOP_MODULE.
// The fetch side (master) supplies instruction words; the sequencer (slave) returns the datapath controls.
interface control_sequencer_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        fetch_stall;
    logic        ctrl_valid;
    logic        RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl;
    logic        ShortBr, LongBr, MemRead, MemWrite, BranchReg;
    logic [1:0]  ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg;
    logic        halted;
    logic        illegal;

    modport master (
        output instr_valid, instr,
        input  fetch_stall, ctrl_valid,
        input  RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl,
        input  ShortBr, LongBr, MemRead, MemWrite, BranchReg,
        input  ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg,
        input  halted, illegal
    );

    modport slave (
        input  instr_valid, instr,
        output fetch_stall, ctrl_valid,
        output RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl,
        output ShortBr, LongBr, MemRead, MemWrite, BranchReg,
        output ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg,
        output halted, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// KGP-miniRISC control sequencer: registered instruction decoder plus a small
// RUN/FLUSH/LWAIT/HALT FSM that squashes wrong-path slots, stalls on loads and halts.
module control_sequencer #(
    parameter int FLUSH_CYCLES = 1,
    parameter int LOAD_WAIT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    control_sequencer_if.slave   bus
);
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_LWAIT = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);
    localparam logic [1:0] LWAIT_INIT = 2'(LOAD_WAIT);
    localparam logic       LOAD_STALLS = (LOAD_WAIT > 0);

    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;
    localparam logic [1:0] SH_LL   = 2'b00;
    localparam logic [1:0] SH_RL   = 2'b01;
    localparam logic [1:0] SH_RA   = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       imm_sel;
        logic       alu_src;
        logic       comp_enbl;
        logic       shift_amnt_sel;
        logic       shift_enbl;
        logic       short_br;
        logic       long_br;
        logic       mem_read;
        logic       mem_write;
        logic       branch_reg;
        logic [1:0] alu_op;
        logic [1:0] reg_dst;
        logic [1:0] shift_type;
        logic [1:0] branch_type;
        logic [1:0] jump_type;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    typedef struct packed {
        ctrl_t ctrl;
        logic  legal;
        logic  illegal;
        logic  branch;
        logic  load;
        logic  halt;
    } dec_t;

    // Pure decode of one instruction word into controls plus FSM classification.
    function automatic dec_t decode(input logic [5:0] op, input logic [4:0] fn);
        dec_t d;
        d       = '0;
        d.legal = 1'b1;
        case (op)
            6'd0: begin
                d.ctrl.reg_write = 1'b1;
                d.ctrl.alu_op    = ALU_ADD;
                case (fn)
                    5'd0: d.ctrl.alu_op = ALU_ADD;
                    5'd1: d.ctrl.comp_enbl = 1'b1;
                    5'd2: d.ctrl.alu_op = ALU_AND;
                    5'd3: d.ctrl.alu_op = ALU_XOR;
                    5'd4: begin d.ctrl.shift_enbl = 1'b1; d.ctrl.shift_type = SH_LL; end
                    5'd5: begin d.ctrl.shift_enbl = 1'b1; d.ctrl.shift_type = SH_RL; end
                    5'd8: begin d.ctrl.shift_enbl = 1'b1; d.ctrl.shift_type = SH_RA; end
                    5'd6: begin d.ctrl.shift_enbl = 1'b1; d.ctrl.shift_amnt_sel = 1'b1; d.ctrl.shift_type = SH_LL; end
                    5'd7: begin d.ctrl.shift_enbl = 1'b1; d.ctrl.shift_amnt_sel = 1'b1; d.ctrl.shift_type = SH_RL; end
                    5'd9: begin d.ctrl.shift_enbl = 1'b1; d.ctrl.shift_amnt_sel = 1'b1; d.ctrl.shift_type = SH_RA; end
                    default: begin d.ctrl = '0; d.legal = 1'b0; d.illegal = 1'b1; end
                endcase
            end
            6'd1, 6'd2: begin
                d.ctrl.reg_write = 1'b1;
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.alu_op    = ALU_ADD;
                d.ctrl.comp_enbl = (op == 6'd2);
            end
            6'd3: begin
                d.ctrl.reg_write  = 1'b1;
                d.ctrl.alu_src    = 1'b1;
                d.ctrl.alu_op     = ALU_ADD;
                d.ctrl.mem_read   = 1'b1;
                d.ctrl.mem_to_reg = 2'b01;
                d.ctrl.reg_dst    = 2'b01;
                d.load            = 1'b1;
            end
            6'd4: begin
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.alu_op    = ALU_ADD;
                d.ctrl.mem_write = 1'b1;
                d.ctrl.imm_sel   = 1'b1;
            end
            6'd5: begin d.ctrl.branch_reg = 1'b1; d.branch = 1'b1; end
            6'd6: begin d.ctrl.short_br = 1'b1; d.ctrl.branch_type = 2'b01; d.branch = 1'b1; end
            6'd7: begin d.ctrl.short_br = 1'b1; d.ctrl.branch_type = 2'b10; d.branch = 1'b1; end
            6'd8: begin d.ctrl.short_br = 1'b1; d.ctrl.branch_type = 2'b11; d.branch = 1'b1; end
            6'd9: begin d.ctrl.long_br = 1'b1; d.branch = 1'b1; end
            6'd10: begin
                d.ctrl.long_br    = 1'b1;
                d.ctrl.reg_write  = 1'b1;
                d.ctrl.reg_dst    = 2'b10;
                d.ctrl.mem_to_reg = 2'b10;
                d.branch          = 1'b1;
            end
            6'd11: begin d.ctrl.long_br = 1'b1; d.ctrl.jump_type = 2'b01; d.branch = 1'b1; end
            6'd12: begin d.ctrl.long_br = 1'b1; d.ctrl.jump_type = 2'b10; d.branch = 1'b1; end
            6'd63: begin d.legal = 1'b0; d.halt = 1'b1; end
            default: begin d.legal = 1'b0; d.illegal = 1'b1; end
        endcase
        return d;
    endfunction

    logic [1:0] r_state;
    logic [1:0] r_cnt;
    ctrl_t      r_ctrl;
    logic       r_valid;
    logic       r_halted;
    logic       r_illegal;
    dec_t       w_dec;
    logic       w_unused;

    // Decode the word on the bus every cycle; only used when it is accepted.
    always_comb begin
        w_dec    = decode(bus.instr[31:26], bus.instr[4:0]);
        w_unused = ^bus.instr[25:5];
    end

    // Sequencer FSM and registered control bundle; outputs default to NOP each cycle
    // so single-cycle pulses never repeat across squashed or stalled slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_cnt     <= 2'd0;
            r_ctrl    <= '0;
            r_valid   <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (bus.instr_valid) begin
                        r_ctrl  <= w_dec.ctrl;
                        r_valid <= w_dec.legal;
                        if (w_dec.illegal) begin
                            r_illegal <= 1'b1;
                        end
                        if (w_dec.halt) begin
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end else if (w_dec.branch) begin
                            r_state <= ST_FLUSH;
                            r_cnt   <= FLUSH_INIT;
                        end else if (w_dec.load && LOAD_STALLS) begin
                            r_state <= ST_LWAIT;
                            r_cnt   <= LWAIT_INIT;
                        end
                    end
                end
                ST_FLUSH, ST_LWAIT: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt <= 2'd1) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign bus.fetch_stall  = (r_state == ST_LWAIT) || (r_state == ST_HALT);
    assign bus.ctrl_valid   = r_valid;
    assign bus.halted       = r_halted;
    assign bus.illegal      = r_illegal;
    assign bus.RegWrite     = r_ctrl.reg_write;
    assign bus.ImmSel       = r_ctrl.imm_sel;
    assign bus.ALUSrc       = r_ctrl.alu_src;
    assign bus.CompEnbl     = r_ctrl.comp_enbl;
    assign bus.ShiftAmntSel = r_ctrl.shift_amnt_sel;
    assign bus.ShiftEnbl    = r_ctrl.shift_enbl;
    assign bus.ShortBr      = r_ctrl.short_br;
    assign bus.LongBr       = r_ctrl.long_br;
    assign bus.MemRead      = r_ctrl.mem_read;
    assign bus.MemWrite     = r_ctrl.mem_write;
    assign bus.BranchReg    = r_ctrl.branch_reg;
    assign bus.ALUOp        = r_ctrl.alu_op;
    assign bus.RegDst       = r_ctrl.reg_dst;
    assign bus.ShiftType    = r_ctrl.shift_type;
    assign bus.BranchType   = r_ctrl.branch_type;
    assign bus.JumpType     = r_ctrl.jump_type;
    assign bus.MemToReg     = r_ctrl.mem_to_reg;
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus a randomized
// instruction stream checked against a slot-counting behavioural model.
module tb_control_sequencer;
    localparam int FLUSH_CYCLES = 1;
    localparam int LOAD_WAIT    = 1;

    localparam int K_PLAIN = 0;
    localparam int K_BR    = 1;
    localparam int K_LOAD  = 2;
    localparam int K_HALT  = 3;
    localparam int K_ILL   = 4;

    typedef struct packed {
        logic       valid, stall, halted, illegal;
        logic       rw, imm, alusrc, comp, sas, se, sbr, lbr, mr, mw, brr;
        logic [1:0] aluop, regdst, stype, btype, jtype, m2r;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    int   m_squash = 0;
    int   m_stall  = 0;
    bit   m_halt   = 1'b0;
    bit   m_ill    = 1'b0;
    obs_t m_exp    = '0;

    control_sequencer_if bus ();

    control_sequencer #(.FLUSH_CYCLES(FLUSH_CYCLES), .LOAD_WAIT(LOAD_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        obs_t o;
        o = {bus.ctrl_valid, bus.fetch_stall, bus.halted, bus.illegal,
             bus.RegWrite, bus.ImmSel, bus.ALUSrc, bus.CompEnbl, bus.ShiftAmntSel, bus.ShiftEnbl,
             bus.ShortBr, bus.LongBr, bus.MemRead, bus.MemWrite, bus.BranchReg,
             bus.ALUOp, bus.RegDst, bus.ShiftType, bus.BranchType, bus.JumpType, bus.MemToReg};
        return o;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] fn);
        return {op, 21'($urandom), fn};
    endfunction

    // Reference controls from the instruction table, using op arithmetic for the branch families.
    function automatic obs_t ref_ctrl(input logic [5:0] op, input logic [4:0] fn, output int kind);
        obs_t c;
        c = '0;
        kind = K_PLAIN;
        c.valid = 1'b1;
        if (op == 6'd0) begin
            c.rw = 1'b1;
            c.aluop = 2'b01;
            if (fn inside {5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9}) begin
                c.se    = 1'b1;
                c.sas   = (fn inside {5'd6, 5'd7, 5'd9});
                c.stype = (fn == 5'd4 || fn == 5'd6) ? 2'b00 : (fn == 5'd5 || fn == 5'd7) ? 2'b01 : 2'b10;
            end else if (fn == 5'd1) c.comp = 1'b1;
            else if (fn == 5'd2) c.aluop = 2'b10;
            else if (fn == 5'd3) c.aluop = 2'b11;
            else if (fn != 5'd0) kind = K_ILL;
        end else if (op == 6'd1 || op == 6'd2) begin
            c.rw = 1'b1; c.alusrc = 1'b1; c.aluop = 2'b01; c.comp = (op == 6'd2);
        end else if (op == 6'd3) begin
            c.rw = 1'b1; c.alusrc = 1'b1; c.aluop = 2'b01; c.mr = 1'b1; c.m2r = 2'b01; c.regdst = 2'b01;
            kind = K_LOAD;
        end else if (op == 6'd4) begin
            c.alusrc = 1'b1; c.aluop = 2'b01; c.mw = 1'b1; c.imm = 1'b1;
        end else if (op >= 6'd5 && op <= 6'd12) begin
            kind  = K_BR;
            c.brr = (op == 6'd5);
            c.sbr = (op >= 6'd6 && op <= 6'd8);
            c.btype = c.sbr ? 2'(op - 6'd5) : 2'b00;
            c.lbr = (op >= 6'd9);
            c.jtype = (op >= 6'd11) ? 2'(op - 6'd10) : 2'b00;
            if (op == 6'd10) begin
                c.rw = 1'b1; c.regdst = 2'b10; c.m2r = 2'b10;
            end
        end else if (op == 6'd63) kind = K_HALT;
        else kind = K_ILL;
        if (kind == K_ILL || kind == K_HALT) c = '0;
        return c;
    endfunction

    // One clock: drive the word, advance the model, sample #1 after the edge.
    task automatic step(input logic v, input logic [31:0] ins, output bit consumed);
        obs_t c;
        int   kind;
        bus.instr_valid = v;
        bus.instr       = ins;
        consumed = 1'b0;
        c = '0;
        if (m_halt) begin
            consumed = 1'b0;
        end else if (m_squash > 0) begin
            m_squash--;
            consumed = v;
        end else if (m_stall > 0) begin
            m_stall--;
        end else if (v) begin
            consumed = 1'b1;
            c = ref_ctrl(ins[31:26], ins[4:0], kind);
            if (kind == K_BR) m_squash = FLUSH_CYCLES;
            if (kind == K_LOAD) m_stall = LOAD_WAIT;
            if (kind == K_HALT) m_halt = 1'b1;
            if (kind == K_ILL) m_ill = 1'b1;
        end
        c.stall   = m_halt || (m_stall > 0);
        c.halted  = m_halt;
        c.illegal = m_ill;
        m_exp     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr = $urandom;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        m_squash = 0; m_stall = 0; m_halt = 1'b0; m_ill = 1'b0; m_exp = '0;
    endtask

    task automatic test_reset();
        obs_t e;
        bit   t;
        apply_reset(4);
        n_cmp++;
        if (sample() !== obs_t'(0)) begin
            n_bad++; $display("FAIL reset_state: got %h want %h", sample(), obs_t'(0));
        end
        step(1'b1, mk(6'd1, 5'd0), t);
        e = '0; e.valid = 1'b1; e.rw = 1'b1; e.alusrc = 1'b1; e.aluop = 2'b01;
        n_cmp++;
        if (sample() !== e) begin
            n_bad++; $display("FAIL addi_after_reset: got %h want %h", sample(), e);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        bit   t;
        step(1'b1, mk(6'd0, 5'd1), t);
        o = sample();
        n_cmp++;
        if (o !== m_exp || o.comp !== 1'b1 || o.aluop !== 2'b01 || o.stall !== 1'b0) begin
            n_bad++; $display("FAIL comp_rtype: got %h want %h", o, m_exp);
        end
        step(1'b1, mk(6'd0, 5'd3), t);
        o = sample();
        n_cmp++;
        if (o !== m_exp || o.comp !== 1'b0 || o.aluop !== 2'b11 || o.stall !== 1'b0) begin
            n_bad++; $display("FAIL xor_rtype: got %h want %h", o, m_exp);
        end
    endtask

    task automatic test_branch();
        obs_t o;
        bit   t;
        step(1'b1, mk(6'd9, 5'd0), t);
        o = sample();
        n_cmp++;
        if (o !== m_exp || o.lbr !== 1'b1 || o.valid !== 1'b1) begin
            n_bad++; $display("FAIL branch_issue: got %h want %h", o, m_exp);
        end
        step(1'b1, mk(6'd0, 5'd0), t);
        o = sample();
        n_cmp++;
        if (o !== m_exp || o.valid !== 1'b0 || o.lbr !== 1'b0 || o.stall !== 1'b0) begin
            n_bad++; $display("FAIL branch_squash: got %h want %h", o, m_exp);
        end
        step(1'b1, mk(6'd1, 5'd0), t);
        o = sample();
        n_cmp++;
        if (o !== m_exp || o.valid !== 1'b1) begin
            n_bad++; $display("FAIL after_squash: got %h want %h", o, m_exp);
        end
    endtask

    task automatic test_load();
        obs_t o;
        bit   t;
        logic [31:0] nxt;
        nxt = mk(6'd1, 5'd0);
        step(1'b1, mk(6'd3, 5'd0), t);
        o = sample();
        n_cmp++;
        if (o !== m_exp || o.mr !== 1'b1 || o.m2r !== 2'b01 || o.stall !== 1'b1) begin
            n_bad++; $display("FAIL load_issue: got %h want %h", o, m_exp);
        end
        step(1'b1, nxt, t);
        o = sample();
        n_cmp++;
        if (o !== m_exp || o.valid !== 1'b0 || o.mr !== 1'b0 || t !== 1'b0) begin
            n_bad++; $display("FAIL load_wait: got %h want %h", o, m_exp);
        end
        step(1'b1, nxt, t);
        o = sample();
        n_cmp++;
        if (o !== m_exp || o.valid !== 1'b1 || o.rw !== 1'b1) begin
            n_bad++; $display("FAIL load_resume: got %h want %h", o, m_exp);
        end
    endtask

    task automatic test_illegal();
        obs_t o;
        bit   t;
        step(1'b1, mk(6'd20, 5'd0), t);
        o = sample();
        n_cmp++;
        if (o !== m_exp || o.illegal !== 1'b1 || o.valid !== 1'b0) begin
            n_bad++; $display("FAIL illegal_op: got %h want %h", o, m_exp);
        end
        step(1'b1, mk(6'd0, 5'd31), t);
        o = sample();
        n_cmp++;
        if (o !== m_exp || o.illegal !== 1'b1 || o.valid !== 1'b0 || o.rw !== 1'b0) begin
            n_bad++; $display("FAIL illegal_funct: got %h want %h", o, m_exp);
        end
        step(1'b1, mk(6'd1, 5'd0), t);
        o = sample();
        n_cmp++;
        if (o !== m_exp || o.valid !== 1'b1 || o.illegal !== 1'b1) begin
            n_bad++; $display("FAIL illegal_then_addi: got %h want %h", o, m_exp);
        end
    endtask

    task automatic test_halt();
        obs_t o;
        bit   t;
        step(1'b1, mk(6'd63, 5'd0), t);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(1'b1, mk(6'd4, 5'd0), t);
            o = sample();
            n_cmp++;
            if (o !== m_exp || o.halted !== 1'b1 || o.stall !== 1'b1 || o.valid !== 1'b0 || o.mw !== 1'b0) begin
                n_bad++; $display("FAIL halt_hold[%0d]: got %h want %h", i, o, m_exp);
            end
        end
        apply_reset(1);
        step(1'b1, mk(6'd2, 5'd0), t);
        o = sample();
        n_cmp++;
        if (o !== m_exp || o.halted !== 1'b0 || o.valid !== 1'b1 || o.comp !== 1'b1) begin
            n_bad++; $display("FAIL halt_reset_resume: got %h want %h", o, m_exp);
        end
    endtask

    task automatic test_random();
        logic [31:0] cur;
        logic        cur_v;
        bit          took;
        int          r;
        obs_t        o;
        cur_v = 1'b1;
        cur   = mk(6'd1, 5'd0);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0 || (m_halt && $urandom_range(0, 7) == 0)) begin
                apply_reset(1);
            end
            step(cur_v, cur, took);
            o = sample();
            n_cmp++;
            if (o !== m_exp) begin
                n_bad++; $display("FAIL random[%0d] instr=%h: got %h want %h", i, cur, o, m_exp);
            end
            if (took || !cur_v || m_halt) begin
                cur_v = ($urandom_range(0, 5) != 0);
                r = $urandom_range(0, 99);
                if (r < 60) cur = mk(6'($urandom_range(0, 12)), 5'($urandom_range(0, 9)));
                else if (r < 72) cur = mk(6'd0, 5'($urandom));
                else if (r < 74) cur = mk(6'd63, 5'($urandom));
                else cur = $urandom;
            end
        end
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr = 32'd0;
        test_reset();
        test_back_to_back();
        test_branch();
        test_load();
        test_illegal();
        test_halt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
